// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared glyph table, segment bit positions and scan states for seg7_scan
package seg7_pkg;

    typedef enum logic {
        SHOW = 1'b0,
        DEAD = 1'b1
    } state_t;

    localparam int SEG_A  = 7;
    localparam int SEG_B  = 6;
    localparam int SEG_C  = 5;
    localparam int SEG_D  = 4;
    localparam int SEG_E  = 3;
    localparam int SEG_F  = 2;
    localparam int SEG_G  = 1;
    localparam int SEG_DP = 0;

    // Entry n is the active-high pattern for hex digit n; dp bit always clear.
    localparam logic [15:0][7:0] GLYPH_TABLE = {
        8'h8E, 8'h9E, 8'h7A, 8'h9C, 8'h3E, 8'hEE, 8'hF6, 8'hFE,
        8'hE0, 8'hBE, 8'hB6, 8'h66, 8'hF2, 8'hDA, 8'h60, 8'hFC
    };

    function automatic logic [7:0] glyph_of(input logic [3:0] nib);
        return GLYPH_TABLE[nib];
    endfunction

endpackage

// File: rtl/seg7_glyph.sv
// rtl/seg7_glyph.sv - combinational hex nibble to seven-segment glyph lookup
module seg7_glyph
    import seg7_pkg::*;
(
    input  logic [3:0] digit,
    output logic [7:0] glyph
);

    always_comb begin
        glyph = glyph_of(digit);
    end

endmodule

// File: rtl/seg7_scan.sv
// rtl/seg7_scan.sv - multiplexed N-digit seven-segment scanner with frame-aligned commit
// Optional SEG7_LZ_BLANK_EN: leading-zero digits keep their anode but show only dp.
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int DEAD_CYCLES = 2,
    parameter int ACTIVE_LOW  = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [4*DIGITS-1:0] value,
    input  logic [DIGITS-1:0]   dp_in,
    input  logic                load,
    input  logic                blank,
    output logic [7:0]          seg,
    output logic [DIGITS-1:0]   an,
    output logic                frame
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int DW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;

    localparam logic [IW-1:0]     IDX_LAST  = IW'(DIGITS - 1);
    localparam logic [PW-1:0]     PRE_LAST  = PW'(REFRESH_DIV - 1);
    localparam logic [DW-1:0]     DEAD_LAST = DW'((DEAD_CYCLES > 0) ? DEAD_CYCLES - 1 : 0);
    localparam logic [7:0]        SEG_OFF   = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [DIGITS-1:0] AN_OFF    = (ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : '0;

    state_t              state, state_n;
    logic [IW-1:0]       idx, idx_n, idx_inc;
    logic [PW-1:0]       presc, presc_n;
    logic [DW-1:0]       dead_cnt, dead_n;
    logic [4*DIGITS-1:0] pend_val, disp_val, disp_val_n;
    logic [DIGITS-1:0]   pend_dp, disp_dp, disp_dp_n;
    logic                pend;
    logic                entering, frame_n, commit;
    logic [3:0]          digit_n;
    logic                dp_sel, lz;
    logic [7:0]          glyph_seg, seg_raw, seg_n;
    logic [DIGITS-1:0]   an_raw, an_n;
`ifdef SEG7_LZ_BLANK_EN
    logic                hi_zero;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= DEAD;
            idx      <= IDX_LAST;
            presc    <= '0;
            dead_cnt <= '0;
            pend_val <= '0;
            pend_dp  <= '0;
            pend     <= 1'b0;
            disp_val <= '0;
            disp_dp  <= '0;
            seg      <= SEG_OFF;
            an       <= AN_OFF;
            frame    <= 1'b0;
        end else begin
            state    <= state_n;
            idx      <= idx_n;
            presc    <= presc_n;
            dead_cnt <= dead_n;
            disp_val <= disp_val_n;
            disp_dp  <= disp_dp_n;
            seg      <= seg_n;
            an       <= an_n;
            frame    <= frame_n;
            if (load) begin
                pend_val <= value;
                pend_dp  <= dp_in;
            end
            // A load on the commit edge re-arms pend for the following frame.
            if (load) begin
                pend <= 1'b1;
            end else if (commit) begin
                pend <= 1'b0;
            end
        end
    end

    always_comb begin
        state_n  = state;
        idx_n    = idx;
        presc_n  = presc;
        dead_n   = dead_cnt;
        entering = 1'b0;
        idx_inc  = (idx == IDX_LAST) ? '0 : idx + IW'(1);
        case (state)
            SHOW: begin
                if (presc == PRE_LAST) begin
                    presc_n = '0;
                    if (DEAD_CYCLES == 0) begin
                        idx_n    = idx_inc;
                        entering = 1'b1;
                    end else begin
                        state_n = DEAD;
                    end
                end else begin
                    presc_n = presc + PW'(1);
                end
            end
            DEAD: begin
                if (DEAD_CYCLES == 0 || dead_cnt == DEAD_LAST) begin
                    dead_n   = '0;
                    state_n  = SHOW;
                    idx_n    = idx_inc;
                    entering = 1'b1;
                end else begin
                    dead_n = dead_cnt + DW'(1);
                end
            end
            default: state_n = DEAD;
        endcase

        frame_n    = entering && (idx_n == '0);
        commit     = frame_n && pend;
        disp_val_n = commit ? pend_val : disp_val;
        disp_dp_n  = commit ? pend_dp : disp_dp;
    end

    // Outputs are built from next-cycle state so they land on the same edge.
    always_comb begin
        digit_n = 4'h0;
        dp_sel  = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (IW'(i) == idx_n) begin
                digit_n = disp_val_n[4*i +: 4];
                dp_sel  = disp_dp_n[i];
            end
        end
        lz = 1'b0;
`ifdef SEG7_LZ_BLANK_EN
        hi_zero = 1'b1;
        for (int i = DIGITS - 1; i > 0; i--) begin
            hi_zero = hi_zero & (disp_val_n[4*i +: 4] == 4'h0);
            if (IW'(i) == idx_n) begin
                lz = hi_zero;
            end
        end
`endif
    end

    seg7_glyph glyph_u (
        .digit (digit_n),
        .glyph (glyph_seg)
    );

    always_comb begin
        seg_raw = 8'h00;
        an_raw  = '0;
        if (state_n == SHOW && !blank) begin
            seg_raw         = lz ? 8'h00 : glyph_seg;
            seg_raw[SEG_DP] = dp_sel;
            an_raw          = DIGITS'(1) << idx_n;
        end
        seg_n = (ACTIVE_LOW != 0) ? ~seg_raw : seg_raw;
        an_n  = (ACTIVE_LOW != 0) ? ~an_raw : an_raw;
    end

endmodule

// File: tb/tb_seg7_scan.sv
// tb/tb_seg7_scan.sv - self-checking bench for seg7_scan against a time-based display model
module tb_seg7_scan;

    localparam int DIGITS  = 4;
    localparam int REFRESH = 4;
    localparam int DEAD    = 1;
    localparam int SLOT    = REFRESH + DEAD;
    localparam int FRAME   = DIGITS * SLOT;

    localparam logic [7:0] GLYPH_TAB [16] = '{
        8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
        8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E
    };

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] value = '0;
    logic [3:0]  dp_in = '0;
    logic        load = 1'b0;
    logic        blank = 1'b0;
    logic [7:0]  seg, seg_al;
    logic [3:0]  an, an_al;
    logic        frame, frame_al;

    int n_tests = 0;
    int n_fail  = 0;

    int          k;
    logic [15:0] m_pval, m_disp;
    logic [3:0]  m_pdp, m_ddp;
    logic        m_pend;
    logic [7:0]  exp_seg;
    logic [3:0]  exp_an;
    logic        exp_frame;

    always #5 clk = ~clk;

    seg7_scan #(.DIGITS(DIGITS), .REFRESH_DIV(REFRESH), .DEAD_CYCLES(DEAD), .ACTIVE_LOW(0)) dut (
        .clk(clk), .rst(rst), .value(value), .dp_in(dp_in), .load(load), .blank(blank),
        .seg(seg), .an(an), .frame(frame)
    );

    seg7_scan #(.DIGITS(DIGITS), .REFRESH_DIV(REFRESH), .DEAD_CYCLES(DEAD), .ACTIVE_LOW(1)) dut_al (
        .clk(clk), .rst(rst), .value(value), .dp_in(dp_in), .load(load), .blank(blank),
        .seg(seg_al), .an(an_al), .frame(frame_al)
    );

    task automatic model_reset();
        k = 0; m_pval = '0; m_disp = '0; m_pdp = '0; m_ddp = '0; m_pend = 1'b0;
        exp_seg = 8'h00; exp_an = 4'h0; exp_frame = 1'b0;
    endtask

    // Advance one clock; expected outputs follow from cycles elapsed since reset.
    task automatic tick();
        int s, r, d;
        logic lz;
        @(posedge clk);
        k++;
        s = k - ((DEAD > 0) ? DEAD : 1);
        r = (s >= 0) ? s % FRAME : -1;
        exp_frame = (r == 0);
        if (exp_frame && m_pend) begin
            m_disp = m_pval; m_ddp = m_pdp; m_pend = 1'b0;
        end
        if (load) begin
            m_pval = value; m_pdp = dp_in; m_pend = 1'b1;
        end
        exp_seg = 8'h00;
        exp_an  = 4'h0;
        if (r >= 0 && (r % SLOT) < REFRESH && !blank) begin
            d  = r / SLOT;
            lz = 1'b0;
`ifdef SEG7_LZ_BLANK_EN
            lz = (d > 0) && ((m_disp >> (4 * d)) == 16'h0);
`endif
            exp_seg = (lz ? 8'h00 : GLYPH_TAB[m_disp[4*d +: 4]]) | {7'b0, m_ddp[d]};
            exp_an  = 4'(1 << d);
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; load = 1'b1; value = 16'h1234; dp_in = 4'hF; blank = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (seg !== 8'h00 || an !== 4'h0 || frame !== 1'b0 || seg_al !== 8'hFF || an_al !== 4'hF) begin
            n_fail++;
            $display("FAIL reset_state seg/an/frame=%h/%h/%b al=%h/%h want 00/0/0 al FF/F", seg, an, frame, seg_al, an_al);
        end
        load = 1'b0; dp_in = 4'h0; rst = 1'b0;
        model_reset();
        tick();
        n_tests++;
        if (seg !== 8'hFC || an !== 4'b0001 || frame !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_first_frame seg/an/frame=%h/%h/%b want FC/1/1", seg, an, frame);
        end
    endtask

    task automatic test_sequence();
        logic [7:0] want [4] = '{8'hE0, 8'hEE, 8'hDA, 8'h60};
        int start = -1;
        int o;
        logic [7:0] seg_w;
        logic [3:0] an_w;
        for (int c = 0; c < 3 * FRAME; c++) begin
            if (c == 0) begin value = 16'h12A7; dp_in = 4'h0; load = 1'b1; end
            tick();
            load = 1'b0;
            n_tests++;
            if (seg !== exp_seg || an !== exp_an || frame !== exp_frame || seg_al !== ~exp_seg || an_al !== ~exp_an || frame_al !== exp_frame) begin
                n_fail++;
                $display("FAIL seq_model k=%0d got %h/%h/%b al %h/%h/%b want %h/%h/%b", k, seg, an, frame, seg_al, an_al, frame_al, exp_seg, exp_an, exp_frame);
            end
            if (start < 0 && c >= 1 && frame) start = c;
            o = c - start;
            if (start >= 0 && o < FRAME) begin
                an_w  = ((o % SLOT) < REFRESH) ? 4'(1 << (o / SLOT)) : 4'h0;
                seg_w = (an_w != 0) ? want[o / SLOT] : 8'h00;
                n_tests++;
                if (seg !== seg_w || an !== an_w) begin
                    n_fail++;
                    $display("FAIL seq_pattern o=%0d got %h/%h want %h/%h", o, seg, an, seg_w, an_w);
                end
            end
        end
        n_tests++;
        if (start < 0) begin
            n_fail++;
            $display("FAIL seq_frame_timeout got no frame want one");
        end
    endtask

    task automatic test_midframe();
        bit loaded = 0;
        int framed = 0;
        for (int c = 0; c < 4 * FRAME; c++) begin
            if (!loaded && exp_an == 4'b0100) begin
                value = 16'h0003; load = 1'b1; loaded = 1;
            end
            tick();
            load = 1'b0;
            n_tests++;
            if (seg !== exp_seg || an !== exp_an || frame !== exp_frame || seg_al !== ~exp_seg || an_al !== ~exp_an || frame_al !== exp_frame) begin
                n_fail++;
                $display("FAIL mid_model k=%0d got %h/%h/%b al %h/%h/%b want %h/%h/%b", k, seg, an, frame, seg_al, an_al, frame_al, exp_seg, exp_an, exp_frame);
            end
            if (loaded && frame) framed++;
            if (loaded && framed == 0 && an == 4'b1000) begin
                n_tests++;
                if (seg !== 8'h60) begin
                    n_fail++;
                    $display("FAIL mid_old_digit3 got %h want 60", seg);
                end
            end
            if (framed == 1 && frame) begin
                n_tests++;
                if (seg !== 8'hF2) begin
                    n_fail++;
                    $display("FAIL mid_new_digit0 got %h want F2", seg);
                end
            end
        end
        n_tests++;
        if (!loaded || framed == 0) begin
            n_fail++;
            $display("FAIL mid_timeout got loaded=%0d frames=%0d want 1/>0", loaded, framed);
        end
    endtask

    task automatic test_lz();
`ifdef SEG7_LZ_BLANK_EN
        logic [7:0] want [4] = '{8'hFC, 8'hB6, 8'h00, 8'h00};
`else
        logic [7:0] want [4] = '{8'hFC, 8'hB6, 8'hFC, 8'hFC};
`endif
        int start = -1;
        int o;
        for (int c = 0; c < 3 * FRAME; c++) begin
            if (c == 0) begin value = 16'h0050; dp_in = 4'h0; load = 1'b1; end
            tick();
            load = 1'b0;
            n_tests++;
            if (seg !== exp_seg || an !== exp_an || frame !== exp_frame || seg_al !== ~exp_seg || an_al !== ~exp_an || frame_al !== exp_frame) begin
                n_fail++;
                $display("FAIL lz_model k=%0d got %h/%h/%b al %h/%h/%b want %h/%h/%b", k, seg, an, frame, seg_al, an_al, frame_al, exp_seg, exp_an, exp_frame);
            end
            if (start < 0 && c >= 1 && frame) start = c;
            o = c - start;
            if (start >= 0 && o < FRAME && (o % SLOT) == 0) begin
                n_tests++;
                if (seg !== want[o / SLOT] || an !== 4'(1 << (o / SLOT))) begin
                    n_fail++;
                    $display("FAIL lz_digit%0d got %h/%h want %h/%h", o / SLOT, seg, an, want[o / SLOT], 4'(1 << (o / SLOT)));
                end
            end
        end
    endtask

    task automatic test_dp_blank();
        int commit_c = -1;
        int last_f = -1;
        int gaps = 0;
        for (int c = 0; c < 5 * FRAME; c++) begin
            if (c == 0) begin value = 16'h0007; dp_in = 4'b0001; load = 1'b1; end
            tick();
            load = 1'b0;
            n_tests++;
            if (seg !== exp_seg || an !== exp_an || frame !== exp_frame || seg_al !== ~exp_seg || an_al !== ~exp_an || frame_al !== exp_frame) begin
                n_fail++;
                $display("FAIL dpb_model k=%0d got %h/%h/%b al %h/%h/%b want %h/%h/%b", k, seg, an, frame, seg_al, an_al, frame_al, exp_seg, exp_an, exp_frame);
            end
            if (commit_c < 0 && c >= 1 && frame) begin
                commit_c = c;
                n_tests++;
                if (seg !== 8'hE1 || an !== 4'b0001) begin
                    n_fail++;
                    $display("FAIL dp_digit0 got %h/%h want E1/1", seg, an);
                end
                blank = 1'b1;
            end else if (commit_c >= 0) begin
                n_tests++;
                if (seg !== 8'h00 || an !== 4'h0) begin
                    n_fail++;
                    $display("FAIL blank_off got %h/%h want 00/0", seg, an);
                end
                if (frame) begin
                    if (last_f >= 0) begin
                        gaps++;
                        n_tests++;
                        if (c - last_f != FRAME) begin
                            n_fail++;
                            $display("FAIL blank_frame_gap got %0d want %0d", c - last_f, FRAME);
                        end
                    end
                    last_f = c;
                end
            end
        end
        blank = 1'b0;
        n_tests++;
        if (gaps < 2) begin
            n_fail++;
            $display("FAIL blank_frames got %0d gaps want >=2", gaps);
        end
    endtask

    task automatic test_active_low();
        int start = -1;
        for (int c = 0; c < 3 * FRAME && start < 0; c++) begin
            if (c == 0) begin value = 16'h0007; dp_in = 4'h0; load = 1'b1; end
            tick();
            load = 1'b0;
            if (c >= 1 && frame) start = c;
        end
        n_tests++;
        if (start < 0 || seg_al !== 8'h1F || an_al !== 4'hE) begin
            n_fail++;
            $display("FAIL al_digit0 got %h/%h want 1F/E", seg_al, an_al);
        end
        value = 16'h0009; load = 1'b1;
        tick();
        load = 1'b0;
        rst = 1'b1;
        #1;
        n_tests++;
        if (seg_al !== 8'hFF || an_al !== 4'hF || seg !== 8'h00 || an !== 4'h0 || frame !== 1'b0) begin
            n_fail++;
            $display("FAIL al_async_reset got al %h/%h seg/an/frame %h/%h/%b want FF/F 00/0/0", seg_al, an_al, seg, an, frame);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        tick();
        n_tests++;
        if (seg !== 8'hFC || an !== 4'b0001 || frame !== 1'b1 || seg_al !== 8'h03 || an_al !== 4'hE) begin
            n_fail++;
            $display("FAIL reset_drops_pending got %h/%h/%b al %h/%h want FC/1/1 al 03/E", seg, an, frame, seg_al, an_al);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            value = 16'($urandom);
            dp_in = 4'($urandom);
            load  = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 29) == 0) blank = ~blank;
            tick();
            load = 1'b0;
            n_tests++;
            if (seg !== exp_seg || an !== exp_an || frame !== exp_frame || seg_al !== ~exp_seg || an_al !== ~exp_an || frame_al !== exp_frame) begin
                n_fail++;
                $display("FAIL rand_model k=%0d got %h/%h/%b al %h/%h/%b want %h/%h/%b", k, seg, an, frame, seg_al, an_al, frame_al, exp_seg, exp_an, exp_frame);
            end
        end
        blank = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_sequence();
        test_midframe();
        test_lz();
        test_dp_blank();
        test_active_low();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
